// File: rtl/uart_rx_req.sv
`default_nettype none
// ============================================================================
// uart_rx_req: 8N1 UART receiver that packs four bytes into a 32-bit request
// word. Includes a 2-entry word FIFO and framing/overrun reporting.
// Revision: 1.0
// ============================================================================
module uart_rx_req #(
  parameter int CLKS_PER_BIT = 434,
  parameter int TIMEOUT_CLKS = 43400
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  output logic        req_vaild,
  input  logic        req_ready,
  output logic [31:0] r_in,
  output logic        frame_err,
  output logic        overrun,
  output logic        rx_busy
);

  localparam int                 C_CNT_W     = $clog2(CLKS_PER_BIT);
  localparam int                 C_TO_W      = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [C_CNT_W-1:0] C_BIT_LAST  = C_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [C_CNT_W-1:0] C_HALF_LAST = C_CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [C_TO_W-1:0]  C_TO_LAST   = C_TO_W'(TIMEOUT_CLKS - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic               sync1_q, rxs_q;
  state_t             state_q;
  logic [C_CNT_W-1:0] cnt_q;
  logic [2:0]         bit_cnt_q;
  logic [7:0]         shift_q;
  logic [1:0]         idx_q;
  logic [23:0]        word_q;
  logic [C_TO_W-1:0]  to_cnt_q;
  logic               frame_err_q;

  logic [31:0]        head_q, tail_q;
  logic [1:0]         fifo_cnt_q;
  logic               overrun_q;

  logic               byte_done, push, pop, push_ok;
  logic [31:0]        push_word;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
    end else begin
      sync1_q <= rx;
      rxs_q   <= sync1_q;
    end
  end

  assign byte_done = (state_q == S_STOP) && (cnt_q == C_BIT_LAST) && rxs_q;
  assign push      = byte_done && (idx_q == 2'd3);
  assign push_word = {shift_q, word_q};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      idx_q       <= '0;
      word_q      <= '0;
      to_cnt_q    <= '0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          cnt_q     <= '0;
          bit_cnt_q <= '0;
          if (!rxs_q) begin
            state_q  <= S_START;
            to_cnt_q <= '0;
          end else if (idx_q != 2'd0) begin
            // Stale partial word: drop it after a long quiet line
            if (to_cnt_q == C_TO_LAST) begin
              idx_q    <= '0;
              to_cnt_q <= '0;
            end else begin
              to_cnt_q <= to_cnt_q + C_TO_W'(1);
            end
          end
        end
        S_START: begin
          if (cnt_q == C_HALF_LAST) begin
            cnt_q   <= '0;
            state_q <= rxs_q ? S_IDLE : S_DATA;
          end else begin
            cnt_q <= cnt_q + C_CNT_W'(1);
          end
        end
        S_DATA: begin
          if (cnt_q == C_BIT_LAST) begin
            cnt_q     <= '0;
            shift_q   <= {rxs_q, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_q <= S_STOP;
          end else begin
            cnt_q <= cnt_q + C_CNT_W'(1);
          end
        end
        S_STOP: begin
          if (cnt_q == C_BIT_LAST) begin
            cnt_q   <= '0;
            state_q <= S_IDLE;
            if (rxs_q) begin
              idx_q <= idx_q + 2'd1;
              case (idx_q)
                2'd0:    word_q[7:0]   <= shift_q;
                2'd1:    word_q[15:8]  <= shift_q;
                2'd2:    word_q[23:16] <= shift_q;
                default: ;
              endcase
            end else begin
              frame_err_q <= 1'b1;
              idx_q       <= '0;
            end
          end else begin
            cnt_q <= cnt_q + C_CNT_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign pop     = (fifo_cnt_q != 2'd0) && req_ready;
  assign push_ok = push && ((fifo_cnt_q != 2'd2) || pop);

  // head_q doubles as the output register, so it keeps the last popped word
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      fifo_cnt_q <= '0;
      overrun_q  <= 1'b0;
    end else begin
      overrun_q <= push && !push_ok;
      case (fifo_cnt_q)
        2'd0: begin
          if (push) begin
            head_q     <= push_word;
            fifo_cnt_q <= 2'd1;
          end
        end
        2'd1: begin
          case ({push, pop})
            2'b11: head_q <= push_word;
            2'b01: fifo_cnt_q <= 2'd0;
            2'b10: begin
              tail_q     <= push_word;
              fifo_cnt_q <= 2'd2;
            end
            default: ;
          endcase
        end
        default: begin
          if (pop) begin
            head_q <= tail_q;
            if (push) tail_q <= push_word;
            else fifo_cnt_q <= 2'd1;
          end
        end
      endcase
    end
  end

  assign req_vaild = (fifo_cnt_q != 2'd0);
  assign r_in      = head_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign rx_busy   = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_req.sv
`default_nettype none
// ============================================================================
// tb_uart_rx_req: directed bench with a table of 4-byte words plus hand-made
// sequences for backpressure, framing error, glitch, timeout and reset.
// Revision: 1.0
// ============================================================================
module tb_uart_rx_req;

  localparam int CPB = 8;
  localparam int TO  = 200;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx;
  logic        req_ready;
  logic        req_vaild;
  logic [31:0] r_in;
  logic        frame_err;
  logic        overrun;
  logic        rx_busy;

  uart_rx_req #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .req_vaild (req_vaild),
    .req_ready (req_ready),
    .r_in      (r_in),
    .frame_err (frame_err),
    .overrun   (overrun),
    .rx_busy   (rx_busy)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] got[$];
  int          pop_cyc[$];
  int          cyc = 0;
  int          fe_cnt = 0;
  int          ov_cnt = 0;
  int          busy_cnt = 0;

  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      if (req_vaild && req_ready) begin
        got.push_back(r_in);
        pop_cyc.push_back(cyc);
      end
      if (frame_err) fe_cnt++;
      if (overrun)   ov_cnt++;
      if (rx_busy)   busy_cnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stop_bit;
    tick(CPB);
    rx = 1'b1;
  endtask

  task automatic send_word(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3);
    send_byte(b0, 1'b1);
    send_byte(b1, 1'b1);
    send_byte(b2, 1'b1);
    send_byte(b3, 1'b1);
  endtask

  task automatic wait_words(input int n, input int budget);
    int left;
    left = budget;
    while (got.size() < n && left > 0) begin
      tick(1);
      left--;
    end
  endtask

  typedef struct {
    logic [7:0]  b0, b1, b2, b3;
    logic [31:0] exp_word;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int fe0, ov0, b0;

    vecs[0] = '{8'h78, 8'h56, 8'h34, 8'h12, 32'h12345678};
    vecs[1] = '{8'h00, 8'h00, 8'h00, 8'h00, 32'h00000000};
    vecs[2] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 32'hFFFFFFFF};
    vecs[3] = '{8'h01, 8'h80, 8'h7F, 8'hFE, 32'hFE7F8001};
    vecs[4] = '{8'hA5, 8'h5A, 8'hC3, 8'h3C, 32'h3CC35AA5};

    reset     = 1'b1;
    rx        = 1'b1;
    req_ready = 1'b1;
    tick(3);
    check("rst_vaild", {31'd0, req_vaild}, 32'd0);
    check("rst_r_in",  r_in,               32'd0);
    check("rst_fe",    {31'd0, frame_err}, 32'd0);
    check("rst_ov",    {31'd0, overrun},   32'd0);
    check("rst_busy",  {31'd0, rx_busy},   32'd0);
    reset = 1'b0;
    tick(4);

    // Table of words with the consumer always ready
    for (int v = 0; v < 5; v++) begin
      got.delete();
      fe0 = fe_cnt;
      ov0 = ov_cnt;
      send_word(vecs[v].b0, vecs[v].b1, vecs[v].b2, vecs[v].b3);
      wait_words(1, 40);
      tick(5);
      check($sformatf("vec%0d_count", v), got.size(), 32'd1);
      if (got.size() > 0) check($sformatf("vec%0d_word", v), got[0], vecs[v].exp_word);
      check($sformatf("vec%0d_flags", v), (fe_cnt - fe0) + (ov_cnt - ov0), 32'd0);
    end

    // Backpressure: two words queue, the third overruns
    got.delete();
    pop_cyc.delete();
    ov0 = ov_cnt;
    req_ready = 1'b0;
    send_word(8'h11, 8'h11, 8'h11, 8'h11);
    send_word(8'h22, 8'h22, 8'h22, 8'h22);
    send_word(8'h33, 8'h33, 8'h33, 8'h33);
    tick(4);
    check("bp_overrun", ov_cnt - ov0, 32'd1);
    check("bp_vaild",   {31'd0, req_vaild}, 32'd1);
    check("bp_head",    r_in, 32'h11111111);
    check("bp_nopop",   got.size(), 32'd0);
    req_ready = 1'b1;
    tick(4);
    check("bp_count", got.size(), 32'd2);
    if (got.size() == 2) begin
      check("bp_first",  got[0], 32'h11111111);
      check("bp_second", got[1], 32'h22222222);
      check("bp_back2back", pop_cyc[1] - pop_cyc[0], 32'd1);
    end
    check("bp_empty",    {31'd0, req_vaild}, 32'd0);
    check("bp_lastheld", r_in, 32'h22222222);

    // Framing error drops the partial word
    got.delete();
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    send_byte(8'hCC, 1'b0);
    tick(2 * CPB);
    send_word(8'h01, 8'h02, 8'h03, 8'h04);
    wait_words(1, 40);
    tick(3);
    check("fe_pulses", fe_cnt - fe0, 32'd1);
    check("fe_count",  got.size(), 32'd1);
    if (got.size() > 0) check("fe_word", got[0], 32'h04030201);
    check("fe_ov", ov_cnt - ov0, 32'd0);

    // Glitch between bytes must not disturb the byte index
    got.delete();
    fe0 = fe_cnt;
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    tick(4);
    b0 = busy_cnt;
    rx = 1'b0;
    tick(2);
    rx = 1'b1;
    tick(20);
    check("gl_busy_seen", {31'd0, (busy_cnt - b0) > 0}, 32'd1);
    check("gl_busy_low",  {31'd0, rx_busy}, 32'd0);
    check("gl_noword",    got.size(), 32'd0);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    wait_words(1, 40);
    tick(3);
    check("gl_count", got.size(), 32'd1);
    if (got.size() > 0) check("gl_word", got[0], 32'h44332211);
    check("gl_fe", fe_cnt - fe0, 32'd0);

    // Timeout discards a lone byte
    got.delete();
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    send_byte(8'hDE, 1'b1);
    tick(300);
    send_word(8'h01, 8'h02, 8'h03, 8'h04);
    wait_words(1, 40);
    tick(3);
    check("to_count", got.size(), 32'd1);
    if (got.size() > 0) check("to_word", got[0], 32'h04030201);
    check("to_flags", (fe_cnt - fe0) + (ov_cnt - ov0), 32'd0);

    // Async reset mid-DATA with a word queued
    req_ready = 1'b0;
    send_word(8'h55, 8'h66, 8'h77, 8'h88);
    tick(3);
    check("ar_queued", {31'd0, req_vaild}, 32'd1);
    rx = 1'b0;
    tick(3 * CPB);
    #2 reset = 1'b1;
    #1;
    check("ar_vaild", {31'd0, req_vaild}, 32'd0);
    check("ar_r_in",  r_in,               32'd0);
    check("ar_busy",  {31'd0, rx_busy},   32'd0);
    check("ar_fe",    {31'd0, frame_err}, 32'd0);
    check("ar_ov",    {31'd0, overrun},   32'd0);
    rx = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(2);
    got.delete();
    req_ready = 1'b1;
    send_word(8'hBE, 8'hBA, 8'hFE, 8'hCA);
    wait_words(1, 40);
    tick(3);
    check("ar_count", got.size(), 32'd1);
    if (got.size() > 0) check("ar_word", got[0], 32'hCAFEBABE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
